// File: rtl/divider_param.sv
// Iterative RISC-V M-extension divider (DIV/DIVU/REM/REMU) retiring BITS_PER_CYCLE
// quotient bits per cycle, with single-cycle special cases and a one-entry result cache.
module divider_param #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] OP1_SE,
  input  logic [XLEN-1:0] OP2_SE,
  input  logic [1:0]      CMD_RD,
  input  logic            START_DIV,
  input  logic            KILL_DIV,
  output logic            DONE_DIV,
  output logic            BUSY_DIV,
  output logic [XLEN-1:0] RES_DIV
);

  localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              sgn_q, sgn_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [2*XLEN-1:0] pr_q, pr_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              cv_q, cv_d;
  logic [XLEN-1:0]   c_op1_q, c_op1_d;
  logic [XLEN-1:0]   c_op2_q, c_op2_d;
  logic              c_sgn_q, c_sgn_d;
  logic [XLEN-1:0]   c_quo_q, c_quo_d;
  logic [XLEN-1:0]   c_rem_q, c_rem_d;

  logic [2*XLEN-1:0] pr_v;
  logic [XLEN-1:0]   quo_v;
  logic [XLEN:0]     top_v;
  logic              qbit_v;
  logic [2*XLEN-1:0] run_pr_c;
  logic [XLEN-1:0]   run_quo_c;

  logic              div0_c, ovf_c, hit_c;
  logic [XLEN-1:0]   fix_quo_c, fix_rem_c;

  function automatic logic is_rem(input logic [1:0] c);
    return c[1] == c[0];
  endfunction

  // Chained restoring steps; the top slice is XLEN+1 bits so the shifted-out MSB is kept.
  always_comb begin : run_step
    pr_v   = pr_q;
    quo_v  = quo_q;
    top_v  = '0;
    qbit_v = 1'b0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      top_v = pr_v[2*XLEN-1:XLEN-1];
      if (top_v >= {1'b0, dvs_q}) begin
        top_v  = top_v - {1'b0, dvs_q};
        qbit_v = 1'b1;
      end else begin
        qbit_v = 1'b0;
      end
      pr_v  = {top_v[XLEN-1:0], pr_v[XLEN-2:0], 1'b0};
      quo_v = {quo_v[XLEN-2:0], qbit_v};
    end
    run_pr_c  = pr_v;
    run_quo_c = quo_v;
  end

  assign div0_c    = (OP2_SE == '0);
  assign ovf_c     = CMD_RD[0] && (OP1_SE == MIN_NEG) && (OP2_SE == '1);
  assign hit_c     = cv_q && (c_op1_q == OP1_SE) && (c_op2_q == OP2_SE) && (c_sgn_q == CMD_RD[0]);
  assign fix_quo_c = qneg_q ? -quo_q : quo_q;
  assign fix_rem_c = rneg_q ? -pr_q[2*XLEN-1:XLEN] : pr_q[2*XLEN-1:XLEN];

  always_comb begin : next_state
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cmd_d   = cmd_q;
    sgn_d   = sgn_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    cv_d    = cv_q;
    c_op1_d = c_op1_q;
    c_op2_d = c_op2_q;
    c_sgn_d = c_sgn_q;
    c_quo_d = c_quo_q;
    c_rem_d = c_rem_q;

    case (state_q)
      S_IDLE: begin
        if (START_DIV) begin
          op1_d = OP1_SE;
          op2_d = OP2_SE;
          cmd_d = CMD_RD;
          sgn_d = CMD_RD[0];
          if (div0_c) begin
            res_d   = is_rem(CMD_RD) ? OP1_SE : '1;
            state_d = S_DONE;
          end else if (ovf_c) begin
            res_d   = is_rem(CMD_RD) ? '0 : OP1_SE;
            state_d = S_DONE;
          end else if (hit_c) begin
            res_d   = is_rem(CMD_RD) ? c_rem_q : c_quo_q;
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        dvs_d   = (sgn_q && op2_q[XLEN-1]) ? -op2_q : op2_q;
        pr_d    = {{XLEN{1'b0}}, ((sgn_q && op1_q[XLEN-1]) ? -op1_q : op1_q)};
        quo_d   = '0;
        cnt_d   = '0;
        qneg_d  = sgn_q && (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
        rneg_d  = sgn_q && op1_q[XLEN-1];
        state_d = S_RUN;
      end
      S_RUN: begin
        pr_d  = run_pr_c;
        quo_d = run_quo_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        cv_d    = 1'b1;
        c_op1_d = op1_q;
        c_op2_d = op2_q;
        c_sgn_d = sgn_q;
        c_quo_d = fix_quo_c;
        c_rem_d = fix_rem_c;
        res_d   = is_rem(cmd_q) ? fix_rem_c : fix_quo_c;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: drop any result and cache update computed above.
    if (KILL_DIV) begin
      state_d = S_IDLE;
      res_d   = res_q;
      cv_d    = cv_q;
      c_op1_d = c_op1_q;
      c_op2_d = c_op2_q;
      c_sgn_d = c_sgn_q;
      c_quo_d = c_quo_q;
      c_rem_d = c_rem_q;
    end
  end

  assign done_d = (state_d == S_DONE);
  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      cmd_q   <= '0;
      sgn_q   <= 1'b0;
      dvs_q   <= '0;
      pr_q    <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cv_q    <= 1'b0;
      c_op1_q <= '0;
      c_op2_q <= '0;
      c_sgn_q <= 1'b0;
      c_quo_q <= '0;
      c_rem_q <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cmd_q   <= cmd_d;
      sgn_q   <= sgn_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cv_q    <= cv_d;
      c_op1_q <= c_op1_d;
      c_op2_q <= c_op2_d;
      c_sgn_q <= c_sgn_d;
      c_quo_q <= c_quo_d;
      c_rem_q <= c_rem_d;
    end
  end

  assign DONE_DIV = done_q;
  assign BUSY_DIV = busy_q;
  assign RES_DIV  = res_q;

endmodule

// File: tb/tb_divider_param.sv
// Self-checking bench for divider_param: a radix-2 and a 4-bit-per-cycle instance,
// checked against plain integer arithmetic plus a model of the result cache.
module tb_divider_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] op1, op2;
  logic [1:0]  cmd;
  logic        start_a, start_b, kill_a, kill_b;
  logic        done_a, done_b, busy_a, busy_b;
  logic [31:0] res_a, res_b;

  int n_checks = 0;
  int n_fail   = 0;

  bit          c_valid[2];
  logic [31:0] c_op1[2];
  logic [31:0] c_op2[2];
  bit          c_sgn[2];
  logic [31:0] last_res[2];

  always #5 clk = ~clk;

  divider_param #(.XLEN(32), .BITS_PER_CYCLE(1)) u_a (
    .clk(clk), .reset_n(reset_n), .OP1_SE(op1), .OP2_SE(op2), .CMD_RD(cmd),
    .START_DIV(start_a), .KILL_DIV(kill_a),
    .DONE_DIV(done_a), .BUSY_DIV(busy_a), .RES_DIV(res_a)
  );

  divider_param #(.XLEN(32), .BITS_PER_CYCLE(4)) u_b (
    .clk(clk), .reset_n(reset_n), .OP1_SE(op1), .OP2_SE(op2), .CMD_RD(cmd),
    .START_DIV(start_b), .KILL_DIV(kill_b),
    .DONE_DIV(done_b), .BUSY_DIV(busy_b), .RES_DIV(res_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  function automatic logic [31:0] get_res(input int sel);
    return (sel != 0) ? res_b : res_a;
  endfunction

  // Architectural result from integer arithmetic (truncating signed division).
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] c);
    logic [31:0] q, r;
    longint      sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (c[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return (c == 2'b00 || c == 2'b11) ? r : q;
  endfunction

  function automatic bit is_fast(input int sel, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] c);
    if (b == 32'd0) return 1'b1;
    if (c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return c_valid[sel] && c_op1[sel] == a && c_op2[sel] == b && c_sgn[sel] == c[0];
  endfunction

  task automatic drive_start(input int sel, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] c);
    @(negedge clk);
    op1 = a; op2 = b; cmd = c;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c, input string tag, input bit busy_pulse);
    logic [31:0] exp_r;
    int          e_lat, lat, extra;
    bit          fast, res_moved;
    exp_r = ref_res(a, b, c);
    fast  = is_fast(sel, a, b, c);
    e_lat = fast ? 1 : (((sel != 0) ? 8 : 32) + 3);
    lat = 0; res_moved = 1'b0; extra = 0;
    drive_start(sel, a, b, c);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, " busy_c1"}, 64'(get_busy(sel)), 64'(1));
      if (busy_pulse && k == 6) begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if (get_done(sel)) begin
        lat = k;
        break;
      end
      if (get_res(sel) !== last_res[sel]) res_moved = 1'b1;
      if (busy_pulse && k == 5) begin
        op1 = ~a; op2 = b ^ 32'h5; cmd = ~c;
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(e_lat));
    check({tag, " result"}, 64'(get_res(sel)), 64'(exp_r));
    check({tag, " busy_at_done"}, 64'(get_busy(sel)), 64'(1));
    if (!fast) check({tag, " res_stable"}, 64'(res_moved), 64'(0));
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(get_done(sel)), 64'(0));
    check({tag, " idle_after"}, 64'(get_busy(sel)), 64'(0));
    if (busy_pulse) begin
      for (int k = 0; k < 45; k++) begin
        @(negedge clk);
        if (get_done(sel) || get_busy(sel)) extra++;
      end
      check({tag, " no_queued_start"}, 64'(extra), 64'(0));
    end
    if (!fast) begin
      c_valid[sel] = 1'b1; c_op1[sel] = a; c_op2[sel] = b; c_sgn[sel] = c[0];
    end
    last_res[sel] = exp_r;
  endtask

  task automatic kill_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] c, input int kill_cycle);
    int seen;
    seen = 0;
    drive_start(sel, a, b, c);
    for (int k = 1; k < kill_cycle; k++) begin
      @(negedge clk);
      if (get_done(sel)) seen++;
    end
    @(negedge clk);
    if (sel == 0) kill_a = 1'b1; else kill_b = 1'b1;
    @(posedge clk);
    #1;
    kill_a = 1'b0; kill_b = 1'b0;
    @(negedge clk);
    check("kill busy_next", 64'(get_busy(sel)), 64'(0));
    check("kill res_held", 64'(get_res(sel)), 64'(last_res[sel]));
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (get_done(sel) || get_busy(sel)) seen++;
    end
    check("kill no_done", 64'(seen), 64'(0));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rc;
    int          sel;

    reset_n = 1'b0;
    op1 = '0; op2 = '0; cmd = '0;
    start_a = 1'b0; start_b = 1'b0; kill_a = 1'b0; kill_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      c_valid[i] = 1'b0; c_op1[i] = '0; c_op2[i] = '0; c_sgn[i] = 1'b0; last_res[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset done_a", 64'(done_a), 64'(0));
    check("reset busy_a", 64'(busy_a), 64'(0));
    check("reset res_a", 64'(res_a), 64'(0));
    check("reset res_b", 64'(res_b), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(0, 32'hFFFF_FFF9, 32'd2, 2'b01, "div_neg7_2", 1'b0);
    run_op(0, 32'hFFFF_FFF9, 32'd2, 2'b11, "rem_neg7_2_hit", 1'b0);
    run_op(0, 32'hFFFF_FFFF, 32'h10, 2'b10, "divu_max_16", 1'b0);
    run_op(0, 32'hFFFF_FFFF, 32'h10, 2'b00, "remu_max_16_hit", 1'b0);
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b01, "div_ovf", 1'b0);
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, "rem_ovf", 1'b0);
    run_op(0, 32'h1234, 32'd0, 2'b00, "remu_by0", 1'b0);
    run_op(0, 32'hDEAD_BEEF, 32'd0, 2'b10, "divu_by0", 1'b0);
    run_op(0, 32'hFFFF_FFFF, 32'h10, 2'b11, "rem_sign_miss", 1'b0);
    run_op(1, 32'd100, 32'hFFFF_FFFD, 2'b01, "bpc4_div_100_m3", 1'b0);
    run_op(1, 32'd100, 32'hFFFF_FFFD, 2'b11, "bpc4_rem_hit", 1'b0);

    for (int i = 0; i < 24; i++) begin
      sel = i % 2;
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      rc  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 3) == 0 && c_valid[sel]) begin
        ra = c_op1[sel];
        rb = c_op2[sel];
      end
      run_op(sel, ra, rb, rc, "random", 1'b0);
    end

    run_op(0, 32'h0BAD_F00D, 32'd13, 2'b10, "start_while_busy", 1'b1);

    kill_op(0, 32'd1000, 32'd7, 2'b10, 11);
    run_op(0, 32'd1000, 32'd7, 2'b10, "after_kill_full", 1'b0);

    drive_start(0, 32'h7654_3210, 32'd9, 2'b01);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrun reset busy", 64'(busy_a), 64'(0));
    check("midrun reset done", 64'(done_a), 64'(0));
    check("midrun reset res", 64'(res_a), 64'(0));
    for (int i = 0; i < 2; i++) begin
      c_valid[i] = 1'b0; last_res[i] = '0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(0, 32'd1000, 32'd7, 2'b00, "after_reset_no_hit", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
